// File: rtl/cnt_sched.sv
// Round-robin scheduler that shares one W-bit up-counter among NREQ requesters.
// A granted requester's job runs the counter from 0 to its sampled length, then the
// owner gets a one-cycle done pulse and priority rotates past it.
module cnt_sched #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned W    = 4
) (
   input  logic              clk,
   input  logic              init_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] len,
   output logic [NREQ-1:0]   gnt,
   output logic [W-1:0]      cnt,
   output logic [NREQ-1:0]   done,
   output logic              busy
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e          state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [W-1:0]    cnt_q, cnt_d;
   logic [NREQ-1:0] done_q, done_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   owner_q, owner_d;
   logic [W-1:0]    target_q, target_d;

   logic [W-1:0]    len_arr [NREQ];
   logic            win_valid;
   logic [PW-1:0]   win_idx;
   logic [PW-1:0]   owner_inc;
   int unsigned     arb_idx;

   // Unpack the flat length bus into one entry per requester.
   always_comb begin
      for (int unsigned i = 0; i < NREQ; i++) begin
         len_arr[i] = len[i*W +: W];
      end
   end

   // Pick the first asserted request scanning upward from ptr, wrapping at NREQ.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      arb_idx   = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         arb_idx = 32'(ptr_q) + k;
         if (arb_idx >= NREQ) begin
            arb_idx = arb_idx - NREQ;
         end
         if (!win_valid && req[arb_idx[PW-1:0]]) begin
            win_valid = 1'b1;
            win_idx   = arb_idx[PW-1:0];
         end
      end
   end

   // Priority position just past the current owner, wrapping NREQ-1 -> 0.
   always_comb begin
      owner_inc = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
   end

   // Next-state and registered-output logic for the IDLE -> RUN -> DONE job cycle.
   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      cnt_d    = cnt_q;
      done_d   = '0;
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      target_d = target_q;
      unique case (state_q)
         StIdle: begin
            if (win_valid) begin
               gnt_d          = '0;
               gnt_d[win_idx] = 1'b1;
               owner_d        = win_idx;
               target_d       = len_arr[win_idx];
               cnt_d          = '0;
               state_d        = StRun;
            end
         end
         StRun: begin
            // A dropped request aborts the job even on the terminal count.
            if (!req[owner_q]) begin
               gnt_d   = '0;
               cnt_d   = '0;
               ptr_d   = owner_inc;
               state_d = StIdle;
            end else if (cnt_q != target_q) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               done_d  = gnt_q;
               state_d = StDone;
            end
         end
         StDone: begin
            gnt_d   = '0;
            cnt_d   = '0;
            ptr_d   = owner_inc;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         state_q  <= StIdle;
         gnt_q    <= '0;
         cnt_q    <= '0;
         done_q   <= '0;
         ptr_q    <= '0;
         owner_q  <= '0;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         target_q <= target_d;
      end
   end

   assign gnt  = gnt_q;
   assign cnt  = cnt_q;
   assign done = done_q;
   assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_cnt_sched.sv
// Self-checking bench for cnt_sched: expected done owners are queued when requests are
// driven and popped when the DUT pulses done; cycle-level checks are made inline.
module tb_cnt_sched;

   localparam int unsigned NREQ = 4;
   localparam int unsigned W    = 4;

   logic              clk = 1'b0;
   logic              init_n;
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] len;
   logic [NREQ-1:0]   gnt;
   logic [W-1:0]      cnt;
   logic [NREQ-1:0]   done;
   logic              busy;

   int n_tests = 0;
   int n_fail  = 0;

   logic [NREQ-1:0] exp_q [$];
   logic [NREQ-1:0] exp_v;

   cnt_sched #(.NREQ(NREQ), .W(W)) dut (
      .clk    (clk),
      .init_n (init_n),
      .req    (req),
      .len    (len),
      .gnt    (gnt),
      .cnt    (cnt),
      .done   (done),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   // Hard stop in case something stalls outside the bounded waits.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   task automatic set_len(input int idx, input logic [W-1:0] v);
      len[idx*W +: W] = v;
   endtask

   function automatic logic [NREQ-1:0] pop_exp();
      if (exp_q.size() == 0) return 'x;
      return exp_q.pop_front();
   endfunction

   task automatic test_reset();
      init_n = 1'b0;
      req    = '0;
      len    = '0;
      repeat (2) @(negedge clk);
      n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
      n_tests++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", cnt); end
      n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL rst_done: got %b want 0000", done); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      init_n = 1'b1;
      // Job by req0 moves the pointer to 1.
      req = 4'b0001; set_len(0, 4'd2); exp_q.push_back(4'b0001);
      for (int c = 0; c < 20 && done === 4'b0000; c++) @(negedge clk);
      exp_v = pop_exp();
      n_tests++; if (done !== exp_v) begin n_fail++; $display("FAIL rst_job0_done: got %b want %b", done, exp_v); end
      req = '0;
      @(negedge clk);
      // Start req1, then clear asynchronously mid-run.
      req = 4'b0010; set_len(1, 4'd6);
      @(negedge clk);
      n_tests++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL rst_job1_gnt: got %b want 0010", gnt); end
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 init_n = 1'b0;
      #1;
      n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_gnt: got %b want 0000", gnt); end
      n_tests++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL rst_mid_cnt: got %0d want 0", cnt); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
      n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_done: got %b want 0000", done); end
      @(negedge clk);
      init_n = 1'b1;
      // Pointer is back at 0, so req0 beats req1.
      req = 4'b0011; set_len(0, 4'd1); exp_q.push_back(4'b0001);
      @(negedge clk);
      n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rst_after_gnt: got %b want 0001", gnt); end
      for (int c = 0; c < 20 && done === 4'b0000; c++) @(negedge clk);
      exp_v = pop_exp();
      n_tests++; if (done !== exp_v) begin n_fail++; $display("FAIL rst_after_done: got %b want %b", done, exp_v); end
      req = '0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      req = 4'b0001; set_len(0, 4'd3); exp_q.push_back(4'b0001);
      @(negedge clk);
      n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL basic_gnt: got %b want 0001", gnt); end
      n_tests++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL basic_cnt0: got %0d want 0", cnt); end
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         n_tests++; if (cnt !== 4'(k)) begin n_fail++; $display("FAIL basic_cnt%0d: got %0d want %0d", k, cnt, k); end
         n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL basic_early_done: got %b want 0000", done); end
      end
      @(negedge clk);
      exp_v = pop_exp();
      n_tests++; if (done !== exp_v) begin n_fail++; $display("FAIL basic_done: got %b want %b", done, exp_v); end
      n_tests++; if (cnt !== 4'd3) begin n_fail++; $display("FAIL basic_cnt_hold: got %0d want 3", cnt); end
      req = '0;
      @(negedge clk);
      n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL basic_gnt_fall: got %b want 0000", gnt); end
      n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL basic_done_fall: got %b want 0000", done); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got %b want 0", busy); end
   endtask

   task automatic test_len_zero();
      req = 4'b1000; set_len(3, 4'd0); exp_q.push_back(4'b1000);
      @(negedge clk);
      n_tests++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL len0_gnt: got %b want 1000", gnt); end
      n_tests++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL len0_cnt_run: got %0d want 0", cnt); end
      n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL len0_early_done: got %b want 0000", done); end
      @(negedge clk);
      exp_v = pop_exp();
      n_tests++; if (done !== exp_v) begin n_fail++; $display("FAIL len0_done: got %b want %b", done, exp_v); end
      n_tests++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL len0_cnt_done: got %0d want 0", cnt); end
      req = '0;
      @(negedge clk);
      n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL len0_gnt_fall: got %b want 0000", gnt); end
   endtask

   task automatic test_round_robin();
      int jobs = 0;
      bit reassert = 1'b0;
      for (int i = 0; i < NREQ; i++) set_len(i, 4'd1);
      req = 4'b1111;
      exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
      exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
      for (int c = 0; c < 200 && jobs < 5; c++) begin
         @(negedge clk);
         if (reassert) begin req[0] = 1'b1; reassert = 1'b0; end
         n_tests++; if ($countones(gnt) > 1) begin n_fail++; $display("FAIL rr_onehot: got %b want at most one bit", gnt); end
         if (done !== 4'b0000) begin
            exp_v = pop_exp();
            n_tests++; if (done !== exp_v) begin n_fail++; $display("FAIL rr_order%0d: got %b want %b", jobs, done, exp_v); end
            n_tests++; if (gnt !== done) begin n_fail++; $display("FAIL rr_owner%0d: gnt %b want %b", jobs, gnt, done); end
            req = req & ~done;
            if (jobs == 0) reassert = 1'b1;
            jobs++;
         end
      end
      n_tests++; if (jobs != 5) begin n_fail++; $display("FAIL rr_jobs: got %0d want 5", jobs); end
      req = '0;
      @(negedge clk);
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle: got %b want 0", busy); end
   endtask

   task automatic test_abort();
      req = 4'b0110; set_len(1, 4'd5); set_len(2, 4'd2);
      @(negedge clk);
      n_tests++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL abort_gnt1: got %b want 0010", gnt); end
      for (int c = 0; c < 10 && cnt !== 4'd2; c++) begin
         @(negedge clk);
         n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL abort_early_done: got %b want 0000", done); end
      end
      n_tests++; if (cnt !== 4'd2) begin n_fail++; $display("FAIL abort_cnt2: got %0d want 2", cnt); end
      req[1] = 1'b0;
      @(negedge clk);
      n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL abort_gnt_clr: got %b want 0000", gnt); end
      n_tests++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL abort_cnt_clr: got %0d want 0", cnt); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
      n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL abort_no_done: got %b want 0000", done); end
      req[1] = 1'b1; exp_q.push_back(4'b0100);
      @(negedge clk);
      n_tests++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL abort_next_gnt: got %b want 0100", gnt); end
      for (int c = 0; c < 20 && done === 4'b0000; c++) @(negedge clk);
      exp_v = pop_exp();
      n_tests++; if (done !== exp_v) begin n_fail++; $display("FAIL abort_next_done: got %b want %b", done, exp_v); end
      n_tests++; if (cnt !== 4'd2) begin n_fail++; $display("FAIL abort_next_cnt: got %0d want 2", cnt); end
      req = '0;
      @(negedge clk);
   endtask

   task automatic test_max_len();
      int cycles = 0;
      req = 4'b0100; set_len(2, 4'd15); exp_q.push_back(4'b0100);
      @(negedge clk);
      n_tests++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL max_gnt: got %b want 0100", gnt); end
      // Length is latched at grant; this change must not shorten the job.
      set_len(2, 4'd3);
      for (int c = 0; c < 40 && done === 4'b0000; c++) begin
         @(negedge clk);
         cycles++;
         if (done === 4'b0000) begin
            n_tests++; if (cnt !== 4'(cycles)) begin n_fail++; $display("FAIL max_cnt: got %0d want %0d", cnt, cycles); end
         end
      end
      n_tests++; if (cycles != 16) begin n_fail++; $display("FAIL max_latency: got %0d want 16", cycles); end
      exp_v = pop_exp();
      n_tests++; if (done !== exp_v) begin n_fail++; $display("FAIL max_done: got %b want %b", done, exp_v); end
      n_tests++; if (cnt !== 4'd15) begin n_fail++; $display("FAIL max_cnt_hold: got %0d want 15", cnt); end
      req = '0;
      @(negedge clk);
      n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL max_done_once: got %b want 0000", done); end
      n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL max_gnt_fall: got %b want 0000", gnt); end
      @(negedge clk);
      n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d want 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_len_zero();
      test_round_robin();
      test_abort();
      test_max_len();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
